pe_sched_ctrl: RTL and testbench

Sequencer that drives the controller-side inputs of the PE engine for one tiled convolution pass.
- Scan order per pass: rows outer, input-channel tile middle, columns inner.
- Before every row/channel scan it opens an hsync window of at least Tin+1 cycles, so the PE engine can reload its Tin filter words between scans.
- Generates position flags, frame beat count and end-of-frame, and stalls on IFM buffer readiness.

---
 rtl/pe_sched_ctrl_pkg.sv | 20 ++
 rtl/pe_sched_scan_cnt.sv | 51 +++++
 rtl/pe_sched_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pe_sched_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_sched_ctrl_pkg.sv
// Shared widths, filter-load size and FSM encoding for the PE scheduling controller.
package pe_sched_ctrl_pkg;

    localparam int unsigned W_SIZE       = 9;
    localparam int unsigned W_CHANNEL    = 9;
    localparam int unsigned W_FRAME_SIZE = 20;
    localparam int unsigned W_DELAY      = 12;
    localparam int unsigned Tin          = 4;

    // Shortest hsync window that still lets the PE engine reload Tin filter words.
    localparam logic [W_DELAY-1:0] GAP_MIN = W_DELAY'(Tin + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HSYNC = 2'd1,
        ST_DATA  = 2'd2,
        ST_FEND  = 2'd3
    } state_t;

endpackage

// File: rtl/pe_sched_scan_cnt.sv
// Nested scan position counter: columns inner, channel tile middle, rows outer.
module pe_sched_scan_cnt
    import pe_sched_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 clr,
    input  logic                 en,
    input  logic [W_SIZE-1:0]    cfg_width,
    input  logic [W_SIZE-1:0]    cfg_height,
    input  logic [W_CHANNEL-1:0] cfg_channel,
    output logic [W_SIZE-1:0]    row,
    output logic [W_SIZE-1:0]    col,
    output logic [W_CHANNEL-1:0] chn,
    output logic                 last_col,
    output logic                 last_all
);

    logic last_chn;
    logic last_row;

    assign last_col = (col == cfg_width - W_SIZE'(1));
    assign last_chn = (chn == cfg_channel - W_CHANNEL'(1));
    assign last_row = (row == cfg_height - W_SIZE'(1));
    assign last_all = last_col & last_chn & last_row;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row <= '0;
            col <= '0;
            chn <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
            chn <= '0;
        end else if (en) begin
            if (!last_col) begin
                col <= col + W_SIZE'(1);
            end else begin
                col <= '0;
                if (!last_chn) begin
                    chn <= chn + W_CHANNEL'(1);
                end else begin
                    chn <= '0;
                    row <= last_row ? '0 : row + W_SIZE'(1);
                end
            end
        end
    end

endmodule

// File: rtl/pe_sched_ctrl.sv
// Sequencer driving the PE engine controller inputs for one tiled convolution pass.
module pe_sched_ctrl
    import pe_sched_ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    i_start,
    input  logic [W_SIZE-1:0]       q_width,
    input  logic [W_SIZE-1:0]       q_height,
    input  logic [W_SIZE-1:0]       q_channel,
    input  logic [W_DELAY-1:0]      q_hsync_gap,
    input  logic                    i_ifm_rdy,
    output logic                    c_ctrl_data_run,
    output logic                    c_ctrl_hsync_run,
    output logic [W_SIZE-1:0]       c_row,
    output logic [W_SIZE-1:0]       c_col,
    output logic [W_CHANNEL-1:0]    c_chn,
    output logic [W_FRAME_SIZE-1:0] c_data_count,
    output logic                    c_end_frame,
    output logic                    c_is_first_row,
    output logic                    c_is_last_row,
    output logic                    c_is_first_col,
    output logic                    c_is_last_col,
    output logic                    o_busy,
    output logic                    o_done
);

    state_t                  state_q, state_d;
    logic [W_SIZE-1:0]       cfg_w, cfg_h;
    logic [W_CHANNEL-1:0]    cfg_c;
    logic [W_DELAY-1:0]      cfg_gap, gap_cnt, gap_g;
    logic [W_FRAME_SIZE-1:0] beat_cnt;
    logic                    row_end_q, frame_end_q;
    logic                    load_cfg, issue, zero_dim;
    logic [W_SIZE-1:0]       scan_row, scan_col;
    logic [W_CHANNEL-1:0]    scan_chn;
    logic                    scan_last_col, scan_last_all;

    assign gap_g    = (q_hsync_gap > GAP_MIN) ? q_hsync_gap : GAP_MIN;
    assign zero_dim = (q_width == '0) || (q_height == '0) || (q_channel == '0);

    pe_sched_scan_cnt u_scan (
        .clk         (clk),
        .rstn        (rstn),
        .clr         (load_cfg),
        .en          (issue),
        .cfg_width   (cfg_w),
        .cfg_height  (cfg_h),
        .cfg_channel (cfg_c),
        .row         (scan_row),
        .col         (scan_col),
        .chn         (scan_chn),
        .last_col    (scan_last_col),
        .last_all    (scan_last_all)
    );

    // Outputs are registered from the next state, so a beat issued at an edge
    // (i_ifm_rdy sampled there) is presented in the following cycle; row_end_q
    // and frame_end_q remember what the currently presented beat closed.
    always_comb begin
        state_d  = state_q;
        issue    = 1'b0;
        load_cfg = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    load_cfg = 1'b1;
                    state_d  = zero_dim ? ST_FEND : ST_HSYNC;
                end
            end
            ST_HSYNC: begin
                if (gap_cnt == W_DELAY'(1)) begin
                    state_d = ST_DATA;
                    issue   = i_ifm_rdy;
                end
            end
            ST_DATA: begin
                if (frame_end_q) begin
                    state_d = ST_FEND;
                end else if (row_end_q) begin
                    state_d = ST_HSYNC;
                end else begin
                    issue = i_ifm_rdy;
                end
            end
            ST_FEND: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            cfg_w       <= '0;
            cfg_h       <= '0;
            cfg_c       <= '0;
            cfg_gap     <= '0;
            gap_cnt     <= '0;
            beat_cnt    <= '0;
            row_end_q   <= 1'b0;
            frame_end_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_end_q   <= issue & scan_last_col;
            frame_end_q <= issue & scan_last_all;
            if (load_cfg) begin
                cfg_w    <= q_width;
                cfg_h    <= q_height;
                cfg_c    <= W_CHANNEL'(q_channel);
                cfg_gap  <= gap_g;
                beat_cnt <= '0;
            end else if (issue) begin
                beat_cnt <= beat_cnt + W_FRAME_SIZE'(1);
            end
            if (state_d == ST_HSYNC && state_q != ST_HSYNC) begin
                gap_cnt <= load_cfg ? gap_g : cfg_gap;
            end else if (state_q == ST_HSYNC) begin
                gap_cnt <= gap_cnt - W_DELAY'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            c_ctrl_data_run  <= 1'b0;
            c_ctrl_hsync_run <= 1'b0;
            c_row            <= '0;
            c_col            <= '0;
            c_chn            <= '0;
            c_data_count     <= '0;
            c_end_frame      <= 1'b0;
            c_is_first_row   <= 1'b0;
            c_is_last_row    <= 1'b0;
            c_is_first_col   <= 1'b0;
            c_is_last_col    <= 1'b0;
            o_busy           <= 1'b0;
            o_done           <= 1'b0;
        end else begin
            c_ctrl_data_run  <= issue;
            c_ctrl_hsync_run <= (state_d == ST_HSYNC);
            c_end_frame      <= (state_d == ST_FEND);
            o_done           <= (state_d == ST_FEND);
            o_busy           <= (state_d != ST_IDLE);
            if (issue) begin
                c_row          <= scan_row;
                c_col          <= scan_col;
                c_chn          <= scan_chn;
                c_data_count   <= beat_cnt;
                c_is_first_row <= (scan_row == '0);
                c_is_last_row  <= (scan_row == cfg_h - W_SIZE'(1));
                c_is_first_col <= (scan_col == '0);
                c_is_last_col  <= scan_last_col;
            end
        end
    end

endmodule

// File: tb/tb_pe_sched_ctrl.sv
// Scoreboard bench for pe_sched_ctrl: loop-nest reference model, randomized ready.
module tb_pe_sched_ctrl;
    import pe_sched_ctrl_pkg::*;

    logic                    clk = 1'b0;
    logic                    rstn = 1'b0;
    logic                    i_start = 1'b0;
    logic [W_SIZE-1:0]       q_width = '0;
    logic [W_SIZE-1:0]       q_height = '0;
    logic [W_SIZE-1:0]       q_channel = '0;
    logic [W_DELAY-1:0]      q_hsync_gap = '0;
    logic                    i_ifm_rdy = 1'b0;
    logic                    c_ctrl_data_run, c_ctrl_hsync_run;
    logic [W_SIZE-1:0]       c_row, c_col;
    logic [W_CHANNEL-1:0]    c_chn;
    logic [W_FRAME_SIZE-1:0] c_data_count;
    logic                    c_end_frame, c_is_first_row, c_is_last_row;
    logic                    c_is_first_col, c_is_last_col, o_busy, o_done;

    pe_sched_ctrl dut (
        .clk              (clk),
        .rstn             (rstn),
        .i_start          (i_start),
        .q_width          (q_width),
        .q_height         (q_height),
        .q_channel        (q_channel),
        .q_hsync_gap      (q_hsync_gap),
        .i_ifm_rdy        (i_ifm_rdy),
        .c_ctrl_data_run  (c_ctrl_data_run),
        .c_ctrl_hsync_run (c_ctrl_hsync_run),
        .c_row            (c_row),
        .c_col            (c_col),
        .c_chn            (c_chn),
        .c_data_count     (c_data_count),
        .c_end_frame      (c_end_frame),
        .c_is_first_row   (c_is_first_row),
        .c_is_last_row    (c_is_last_row),
        .c_is_first_col   (c_is_first_col),
        .c_is_last_col    (c_is_last_col),
        .o_busy           (o_busy),
        .o_done           (o_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W_SIZE-1:0]       row;
        logic [W_SIZE-1:0]       col;
        logic [W_CHANNEL-1:0]    chn;
        logic [W_FRAME_SIZE-1:0] cnt;
        logic [3:0]              flags;
    } beat_t;

    beat_t       exp_q[$];
    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned rdy_mode = 0;
    int unsigned exp_g = 0;
    int unsigned exp_len = 0;
    int unsigned ef_seen = 0;
    int unsigned cyc = 0;
    int unsigned start_cyc = 0;
    int unsigned hs_len = 0;
    bit          pass_active = 1'b0;
    bit          have_beat = 1'b0;
    beat_t       last_beat = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({c_ctrl_data_run, c_ctrl_hsync_run, c_row, c_col, c_chn, c_data_count,
                    c_end_frame, c_is_first_row, c_is_last_row, c_is_first_col,
                    c_is_last_col, o_busy, o_done});
    endfunction

    // 0: always ready, 1: toggle every cycle, 2: random (~75% ready)
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       i_ifm_rdy = 1'b1;
            1:       i_ifm_rdy = ~i_ifm_rdy;
            default: i_ifm_rdy = ($urandom_range(0, 3) != 0);
        endcase
    end

    always @(negedge clk) begin
        beat_t act;
        beat_t e;
        cyc++;
        if (!rstn) begin
            exp_q.delete();
            hs_len      = 0;
            pass_active = 1'b0;
            have_beat   = 1'b0;
        end else begin
            act = '{c_row, c_col, c_chn, c_data_count,
                    {c_is_first_row, c_is_last_row, c_is_first_col, c_is_last_col}};
            if (i_start && !o_busy) begin
                start_cyc   = cyc;
                pass_active = 1'b1;
                have_beat   = 1'b0;
            end
            if (c_ctrl_data_run) begin
                check("run_excl", 64'(c_ctrl_hsync_run), 64'd0);
                if (exp_q.size() == 0) begin
                    check("beat_queue", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", 64'(act), 64'(e));
                    if (!have_beat && rdy_mode == 0)
                        check("first_beat_lat", 64'(cyc - start_cyc), 64'(exp_g + 1));
                end
                have_beat = 1'b1;
                last_beat = act;
            end else if (pass_active && have_beat) begin
                check("hold", 64'(act), 64'(last_beat));
            end
            if (c_ctrl_hsync_run) begin
                hs_len++;
            end else if (hs_len != 0) begin
                check("hsync_len", 64'(hs_len), 64'(exp_g));
                hs_len = 0;
            end
            if (c_end_frame || o_done) begin
                check("done_eq_ef", 64'(o_done), 64'(c_end_frame));
                check("ef_queue_empty", 64'(exp_q.size()), 64'd0);
                check("busy_in_fend", 64'(o_busy), 64'd1);
                if (rdy_mode == 0)
                    check("pass_len", 64'(cyc - start_cyc), 64'(exp_len));
                ef_seen++;
                pass_active = 1'b0;
            end
        end
    end

    task automatic run_pass(input int unsigned w, input int unsigned h, input int unsigned c,
                            input int unsigned gap, input int unsigned mode);
        int unsigned g;
        int unsigned n;
        beat_t b;
        g = (gap > Tin + 1) ? gap : Tin + 1;
        n = 0;
        rdy_mode = mode;
        exp_g    = g;
        exp_len  = (w == 0 || h == 0 || c == 0) ? 1 : h * c * (g + w) + 1;
        if (w != 0 && h != 0 && c != 0) begin
            for (int unsigned r = 0; r < h; r++)
                for (int unsigned ch = 0; ch < c; ch++)
                    for (int unsigned col = 0; col < w; col++) begin
                        b.row   = W_SIZE'(r);
                        b.col   = W_SIZE'(col);
                        b.chn   = W_CHANNEL'(ch);
                        b.cnt   = W_FRAME_SIZE'(n);
                        b.flags = {r == 0, r == h - 1, col == 0, col == w - 1};
                        exp_q.push_back(b);
                        n++;
                    end
        end
        @(posedge clk);
        #1;
        q_width     = W_SIZE'(w);
        q_height    = W_SIZE'(h);
        q_channel   = W_SIZE'(c);
        q_hsync_gap = W_DELAY'(gap);
        i_start     = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic wait_end(input int unsigned target, input int unsigned limit);
        for (int unsigned i = 0; i < limit && ef_seen < target; i++) @(posedge clk);
        check("pass_complete", 64'(ef_seen), 64'(target));
    endtask

    initial begin
        int unsigned passes;
        passes = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", all_outputs(), 64'd0);
        rstn = 1'b1;

        run_pass(4, 2, 2, 2, 0);   wait_end(++passes, 500);
        run_pass(4, 2, 2, 2, 1);   wait_end(++passes, 500);
        run_pass(1, 1, 1, 100, 0); wait_end(++passes, 500);
        run_pass(4, 0, 2, 2, 0);   wait_end(++passes, 50);

        // start pulse and width change while busy must not disturb the pass
        run_pass(3, 2, 2, 0, 0);
        repeat (8) @(posedge clk);
        #1;
        q_width = W_SIZE'(7);
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        wait_end(++passes, 500);

        // reset while beat 7 is on the outputs abandons the pass
        run_pass(4, 2, 2, 2, 0);
        for (int unsigned i = 0; i < 300 && exp_q.size() > 8; i++) begin
            @(negedge clk);
            #1;
        end
        check("beat7_reached", 64'(exp_q.size()), 64'd8);
        #2;
        rstn = 1'b0;
        #1;
        check("reset_mid_outputs", all_outputs(), 64'd0);
        repeat (5) @(posedge clk);
        check("no_done_after_reset", 64'(ef_seen), 64'(passes));
        #2;
        rstn = 1'b1;
        run_pass(4, 2, 2, 2, 0);   wait_end(++passes, 500);

        for (int unsigned k = 0; k < 6; k++) begin
            run_pass($urandom_range(1, 5), $urandom_range(1, 3), $urandom_range(1, 3),
                     $urandom_range(0, 9), (k % 2 == 0) ? 2 : 0);
            wait_end(++passes, 2000);
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
